// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage RISC-V pipeline: EX/MEM register, req/ack data port
// with byte lanes, outstanding-access stall, bus timeout and the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCplus4E,
  input  logic [4:0]  RdE,
  input  logic        RegWriteE,
  input  logic        MemReadE,
  input  logic        MemWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic [2:0]  Funct3E,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ALUResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        stallM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCplus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        misalignW,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [31:0]   WriteDataM, PCplus4M;
  logic          MemReadM, MemWriteM;
  logic [1:0]    ResultSrcM;
  logic [2:0]    Funct3M;
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          memopM, alignedM, misalignM, abandon;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [31:0]   loadData;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCplus4M   <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      Funct3M    <= '0;
    end else if (!stallM) begin
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCplus4M   <= PCplus4E;
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemReadM   <= MemReadE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      Funct3M    <= Funct3E;
    end
  end

  assign memopM    = MemReadM | MemWriteM;
  assign misalignM = memopM & ~alignedM;
  // The abandon cycle withdraws the request, so a late ack in that cycle is ignored.
  assign abandon   = (state == WAIT) && (cnt == CNT_LAST);
  assign mem_req   = memopM & alignedM & ~abandon;
  assign stallM    = mem_req & ~mem_ack;
  assign mem_we    = MemWriteM;
  assign mem_addr  = {ALUResultM[31:2], 2'b00};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alignedM  = 1'b1;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    case (Funct3M[1:0])
      2'b00:   alignedM = 1'b1;
      2'b01:   alignedM = ~ALUResultM[0];
      default: alignedM = (ALUResultM[1:0] == 2'b00);
    endcase
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          mem_be    = 4'b0001 << ALUResultM[1:0];
          mem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << ALUResultM[1:0];
          mem_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = WriteDataM;
        end
      endcase
    end else if (MemReadM) begin
      mem_be = 4'b1111;
    end
  end

  always_comb begin
    byteSel  = mem_rdata[7:0];
    halfSel  = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    loadData = mem_rdata;
    case (ALUResultM[1:0])
      2'b00: byteSel = mem_rdata[7:0];
      2'b01: byteSel = mem_rdata[15:8];
      2'b10: byteSel = mem_rdata[23:16];
      2'b11: byteSel = mem_rdata[31:24];
    endcase
    case (Funct3M)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {24'b0, byteSel};
      3'b101:  loadData = {16'b0, halfSel};
      default: loadData = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_req && !mem_ack) begin
          state <= WAIT;
          cnt   <= CW'(1);
        end
        WAIT: if (abandon) begin
          state   <= IDLE;
          cnt     <= '0;
          bus_err <= 1'b1;
        end else if (mem_ack) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A stalled cycle sends a bubble down; otherwise M moves on, squashed if misaligned or abandoned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCplus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      misalignW  <= 1'b0;
    end else if (stallM) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCplus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      misalignW  <= 1'b0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= (MemReadM && mem_req) ? loadData : '0;
      PCplus4W   <= PCplus4M;
      RdW        <= RdM;
      RegWriteW  <= RegWriteM & ~misalignM & ~abandon;
      ResultSrcW <= ResultSrcM;
      misalignW  <= misalignM;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: acts as execute stage and data memory, and compares every
// cycle against a transaction-level model of the stage (cycles-in-M, timeout, W record).
module tb_mem_stage;
  localparam int TIMEOUT = 16;
  localparam int NDIR    = 10;
  localparam int NRAND   = 300;
  localparam int N       = NDIR + NRAND;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] ALUResultE, WriteDataE, PCplus4E, mem_rdata;
  logic [4:0]  RdE;
  logic        RegWriteE, MemReadE, MemWriteE, mem_ack;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic        mem_req, mem_we, RegWriteM, stallM, RegWriteW, misalignW, bus_err;
  logic [31:0] mem_addr, mem_wdata, ALUResultM, ALUResultW, ReadDataW, PCplus4W;
  logic [3:0]  mem_be;
  logic [4:0]  RdM, RdW;
  logic [1:0]  ResultSrcW;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCplus4E(PCplus4E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .Funct3E(Funct3E),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM), .stallM(stallM),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCplus4W(PCplus4W), .RdW(RdW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .misalignW(misalignW), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, wd, pc4, rdata;
    logic [4:0]  rd;
    logic        rw, mr, mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    int          lat;
    bit          litRdOn;
    logic [31:0] litRd;
    int          litStall;
    bit          litBeOn;
    logic [3:0]  litBe;
    logic [31:0] litWdata;
    bit          litBusErr;
  } instr_t;

  typedef struct {
    bit          isInstr;
    int          idx;
    logic [31:0] alu, rdv, pc4;
    logic [4:0]  rd;
    logic        rw, misal;
    logic [1:0]  rs;
    bit          chkRd;
  } wrec_t;

  instr_t prog[N];
  int     checks = 0, errors = 0;
  int     e, mIdx, waitC, dutStall, cycles;
  bit     busErr, busErrNext, expReq, expAck, stall, abandonNow;
  wrec_t  wCur, wNext;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t zeroInstr();
    instr_t t;
    t.alu = '0; t.wd = '0; t.pc4 = '0; t.rdata = '0; t.rd = '0;
    t.rw = 1'b0; t.mr = 1'b0; t.mw = 1'b0; t.rs = '0; t.f3 = '0; t.lat = NEVER;
    t.litRdOn = 0; t.litRd = '0; t.litStall = -1; t.litBeOn = 0; t.litBe = '0;
    t.litWdata = '0; t.litBusErr = 0;
    return t;
  endfunction

  function automatic instr_t getInstr(input int i);
    if (i < 0 || i >= N) return zeroInstr();
    return prog[i];
  endfunction

  function automatic int sizeOf(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit isAligned(input logic [31:0] a, input logic [2:0] f3);
    return (int'(a[1:0]) % sizeOf(f3)) == 0;
  endfunction

  function automatic logic [31:0] loadExt(input logic [31:0] rdata, input logic [31:0] a,
                                          input logic [2:0] f3);
    logic [31:0] v;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    int r;
    v  = rdata >> (8 * int'(a[1:0]));
    sb = v[7:0];
    sh = v[15:0];
    case (f3)
      3'b000:  r = sb;
      3'b001:  r = sh;
      3'b100:  r = int'(v & 32'hFF);
      3'b101:  r = int'(v & 32'hFFFF);
      default: r = int'(v);
    endcase
    return 32'(r);
  endfunction

  function automatic logic [3:0] storeBe(input logic [31:0] a, input logic [2:0] f3);
    int sz = sizeOf(f3);
    return 4'(((1 << sz) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] storeData(input logic [31:0] d, input logic [2:0] f3);
    case (sizeOf(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic instr_t mkAlu(input logic [31:0] alu, input logic [4:0] rd);
    instr_t t = zeroInstr();
    t.alu = alu; t.rd = rd; t.rw = 1'b1; t.pc4 = $urandom; t.wd = $urandom;
    return t;
  endfunction

  function automatic instr_t mkLoad(input logic [31:0] a, input logic [2:0] f3,
                                    input logic [4:0] rd, input int lat, input logic [31:0] rdata);
    instr_t t = zeroInstr();
    t.alu = a; t.f3 = f3; t.rd = rd; t.rw = 1'b1; t.mr = 1'b1; t.rs = 2'b01;
    t.lat = lat; t.rdata = rdata; t.pc4 = $urandom; t.wd = $urandom;
    return t;
  endfunction

  function automatic instr_t mkStore(input logic [31:0] a, input logic [2:0] f3,
                                     input logic [31:0] d, input int lat);
    instr_t t = zeroInstr();
    t.alu = a; t.f3 = f3; t.wd = d; t.mw = 1'b1; t.lat = lat; t.pc4 = $urandom;
    t.rd = 5'($urandom); t.rdata = $urandom;
    return t;
  endfunction

  task automatic buildProgram();
    logic [2:0] ldF3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    prog[0] = mkLoad(32'h100, 3'b010, 5'd5, 0, 32'hDEADBEEF);
    prog[0].litRdOn = 1; prog[0].litRd = 32'hDEADBEEF;
    prog[1] = mkLoad(32'h103, 3'b000, 5'd6, 0, 32'h80123456);
    prog[1].litRdOn = 1; prog[1].litRd = 32'hFFFFFF80;
    prog[2] = mkLoad(32'h103, 3'b100, 5'd6, 1, 32'h80123456);
    prog[2].litRdOn = 1; prog[2].litRd = 32'h00000080;
    prog[3] = mkLoad(32'h102, 3'b001, 5'd7, 0, 32'h80017777);
    prog[3].litRdOn = 1; prog[3].litRd = 32'hFFFF8001;
    prog[4] = mkStore(32'h101, 3'b000, 32'hAABBCC55, 1);
    prog[4].litBeOn = 1; prog[4].litBe = 4'b0010; prog[4].litWdata = 32'h55555555;
    prog[5] = mkStore(32'h102, 3'b001, 32'h1234BEEF, 0);
    prog[5].litBeOn = 1; prog[5].litBe = 4'b1100; prog[5].litWdata = 32'hBEEFBEEF;
    prog[6] = mkLoad(32'h200, 3'b010, 5'd8, 3, 32'hCAFEF00D);
    prog[6].litStall = 3; prog[6].litRdOn = 1; prog[6].litRd = 32'hCAFEF00D;
    prog[7] = mkLoad(32'h300, 3'b010, 5'd9, NEVER, 32'h11111111);
    prog[7].litStall = TIMEOUT - 1; prog[7].litRdOn = 1; prog[7].litRd = 32'h0;
    prog[8] = mkAlu(32'h1234, 5'd10);
    prog[8].litBusErr = 1;
    prog[9] = mkLoad(32'h102, 3'b010, 5'd11, 0, 32'h22222222);
    for (int i = NDIR; i < N; i++) begin
      int k = $urandom_range(0, 9);
      int r = $urandom_range(0, 19);
      int lat = (r < 8) ? 0 : (r < 16) ? $urandom_range(1, 4) : (r < 18) ?
                $urandom_range(5, TIMEOUT - 2) : (r == 18) ? TIMEOUT - 2 : NEVER;
      logic [2:0]  f3 = (k < 7) ? ldF3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      logic [31:0] a  = $urandom;
      if ($urandom_range(0, 9) != 0) a = a & ~32'(sizeOf(f3) - 1);
      if (k < 4) begin
        prog[i] = mkAlu($urandom, 5'($urandom));
        if (k == 3) prog[i].rs = 2'b10;
      end else if (k < 7) prog[i] = mkLoad(a, f3, 5'($urandom), lat, $urandom);
      else                prog[i] = mkStore(a, f3, $urandom, lat);
    end
  endtask

  task automatic driveCycle();
    instr_t c = getInstr(mIdx);
    instr_t n = getInstr(e);
    bit memop, al;
    ALUResultE = n.alu; WriteDataE = n.wd; PCplus4E = n.pc4; RdE = n.rd;
    RegWriteE = n.rw; MemReadE = n.mr; MemWriteE = n.mw; ResultSrcE = n.rs; Funct3E = n.f3;
    memop      = c.mr | c.mw;
    al         = isAligned(c.alu, c.f3);
    expReq     = memop && al && (waitC < TIMEOUT - 1);
    abandonNow = memop && al && (waitC == TIMEOUT - 1);
    expAck     = expReq && (waitC == c.lat);
    mem_ack    = memop ? expAck : 1'($urandom_range(0, 1));
    mem_rdata  = memop ? c.rdata : $urandom;
    stall      = expReq && !expAck;
  endtask

  task automatic compareCycle();
    instr_t c = getInstr(mIdx);
    bit al = isAligned(c.alu, c.f3);
    check("mem_req", 32'(mem_req), 32'(expReq));
    check("stallM", 32'(stallM), 32'(stall));
    check("bus_err", 32'(bus_err), 32'(busErr));
    check("ALUResultM", ALUResultM, c.alu);
    check("RdM", 32'(RdM), 32'(c.rd));
    check("RegWriteM", 32'(RegWriteM), 32'(c.rw));
    if (expReq) begin
      check("mem_we", 32'(mem_we), 32'(c.mw));
      check("mem_addr", mem_addr, c.alu & ~32'h3);
      check("mem_be", 32'(mem_be), c.mw ? 32'(storeBe(c.alu, c.f3)) : 32'hF);
      if (c.mw) check("mem_wdata", mem_wdata, storeData(c.wd, c.f3));
      if (c.litBeOn) begin
        check("lit_be", 32'(mem_be), 32'(c.litBe));
        check("lit_wdata", mem_wdata, c.litWdata);
        check("lit_addr", mem_addr, 32'h100);
      end
    end
    check("RegWriteW", 32'(RegWriteW), 32'(wCur.rw));
    check("misalignW", 32'(misalignW), 32'(wCur.misal));
    if (wCur.isInstr) begin
      check("ALUResultW", ALUResultW, wCur.alu);
      check("PCplus4W", PCplus4W, wCur.pc4);
      check("RdW", 32'(RdW), 32'(wCur.rd));
      check("ResultSrcW", 32'(ResultSrcW), 32'(wCur.rs));
      if (wCur.chkRd) check("ReadDataW", ReadDataW, wCur.rdv);
      if (wCur.idx >= 0 && prog[wCur.idx].litRdOn)
        check($sformatf("lit_rd%0d", wCur.idx), ReadDataW, prog[wCur.idx].litRd);
      if (wCur.idx >= 0 && prog[wCur.idx].litBusErr)
        check("lit_bus_err", 32'(bus_err), 32'h1);
    end
    if (stallM) dutStall++;
    if (!stall && c.litStall >= 0)
      check($sformatf("lit_stall%0d", mIdx), 32'(dutStall), 32'(c.litStall));
    // Outcome of the instruction currently in M, as seen in W after the edge
    wNext = '{isInstr: 0, idx: -1, alu: '0, rdv: '0, pc4: '0, rd: '0, rw: 0, misal: 0,
              rs: '0, chkRd: 0};
    if (!stall) begin
      wNext.isInstr = 1;
      wNext.idx     = (mIdx < N) ? mIdx : -1;
      wNext.alu     = c.alu;
      wNext.pc4     = c.pc4;
      wNext.rd      = c.rd;
      wNext.rs      = c.rs;
      wNext.misal   = (c.mr | c.mw) && !al;
      wNext.rw      = c.rw && !wNext.misal && !abandonNow;
      wNext.chkRd   = c.mr && al;
      wNext.rdv     = abandonNow ? 32'h0 : loadExt(c.rdata, c.alu, c.f3);
    end
    busErrNext = busErr | abandonNow;
  endtask

  initial begin
    buildProgram();
    mIdx = -1; e = 0; waitC = 0; dutStall = 0; cycles = 0; busErr = 0;
    driveCycle();
    #12;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_stallM", 32'(stallM), 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ALUResultM", ALUResultM, 0);
    check("rst_RegWriteW", 32'(RegWriteW), 0);
    check("rst_ReadDataW", ReadDataW, 0);
    check("rst_ResultSrcW", 32'(ResultSrcW), 0);
    check("rst_misalignW", 32'(misalignW), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    #5 reset = 1'b1;
    wCur = '{isInstr: 1, idx: -1, alu: '0, rdv: '0, pc4: '0, rd: '0, rw: 0, misal: 0,
             rs: '0, chkRd: 0};
    compareCycle();
    while (e < N + 3 && cycles < 30000) begin
      @(posedge clk);
      #1;
      cycles++;
      wCur   = wNext;
      busErr = busErrNext;
      if (stall) waitC++;
      else begin
        mIdx = e; e++; waitC = 0; dutStall = 0;
      end
      driveCycle();
      #1;
      compareCycle();
    end
    check("cycle_budget", 32'(cycles < 30000), 1);

    // Reset asserted while a load is waiting on the bus
    ALUResultE = 32'h400; WriteDataE = '0; PCplus4E = 32'h44; RdE = 5'd3; RegWriteE = 1'b1;
    MemReadE = 1'b1; MemWriteE = 1'b0; ResultSrcE = 2'b01; Funct3E = 3'b010; mem_ack = 1'b0;
    @(posedge clk);
    #1;
    ALUResultE = '0; PCplus4E = '0; RdE = '0; RegWriteE = 1'b0; MemReadE = 1'b0;
    ResultSrcE = '0; Funct3E = '0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_stallM", 32'(stallM), 1);
    check("pre_rst_mem_req", 32'(mem_req), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 0);
    check("mid_rst_stallM", 32'(stallM), 0);
    check("mid_rst_ALUResultM", ALUResultM, 0);
    check("mid_rst_RegWriteW", 32'(RegWriteW), 0);
    check("mid_rst_bus_err", 32'(bus_err), 0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_mem_req", 32'(mem_req), 0);
    check("post_rst_stallM", 32'(stallM), 0);
    check("post_rst_bus_err", 32'(bus_err), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline and the consumer of the execute-stage outputs (ALUResultE, WriteDataE, RdE, PCplus4E). It holds the EX/MEM pipeline register, drives a req/ack data-memory port with byte lanes, stalls the pipeline while an access is outstanding, and loads the MEM/WB register with a sign- or zero-extended load result. It also provides a bus-timeout counter and misalignment detection.

## Interface
- TIMEOUT, 16: cycles a request may wait for mem_ack before it is abandoned; ≥2.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- ALUResultE, WriteDataE, PCplus4E  in  32 each  execute-stage results; WriteDataE is the forwarded rs2
- RdE  in  5  destination register
- RegWriteE, MemReadE, MemWriteE  in  1 each  execute-stage control
- ResultSrcE  in  2  00 ALU, 01 memory, 10 PC+4
- Funct3E  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- mem_req  out  1  access request
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned address, {ALUResultM[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  load data, valid when mem_ack=1
- mem_ack  in  1  access completes this cycle
- ALUResultM  out  32  forwarding source for the execute stage
- RdM  out  5, RegWriteM  out  1  to the hazard unit
- stallM  out  1  freezes fetch, decode, execute and the EX/MEM register
- ALUResultW, ReadDataW, PCplus4W  out  32 each  MEM/WB register
- RdW  out  5, RegWriteW  out  1, ResultSrcW  out  2  MEM/WB register
- misalignW  out  1  instruction in W was a misaligned access
- bus_err  out  1  sticky; a bus timeout has occurred

## Operation
- memopM = MemReadM|MemWriteM. alignedM: b/bu always aligned; h/hu need addr[0]=0; w needs addr[1:0]=0.
- mem_req = memopM & alignedM & ~abandon. mem_we = MemWriteM. mem_addr and mem_wdata stay stable while mem_req=1.
- Store lanes:
  - sb: be=0001<<addr[1:0], wdata={4{byte}}
  - sh: be=0011<<addr[1:0], wdata={2{half}}
  - sw: be=1111
- Loads: be=1111. The bytes/halfword selected by addr[1:0] are extended per Funct3M: sign extension for b/h, zero extension for bu/hu.
- FSM:
  - IDLE: if mem_req & ~mem_ack, go to WAIT with cnt=1.
  - WAIT: if mem_ack, go to IDLE. Otherwise, if cnt==TIMEOUT-1, set abandon for one cycle, set bus_err, and go to IDLE. Otherwise cnt+1.
- stallM = mem_req & ~mem_ack.
- EX/MEM register loads on every edge with stallM=0 and holds while stallM=1.
- MEM/WB register:
  - stallM=1: loads a bubble (RegWriteW=0, misalignW=0).
  - stallM=0: loads the M instruction. ReadDataW is the extended rdata, or 0 on abandon.
- A misaligned access issues no request and does not stall. It reaches W with misalignW=1 and RegWriteW forced to 0.
- An abandoned load reaches W with RegWriteW=0. An abandoned store is dropped. bus_err stays 1 until reset.

## Timing
- Reset: every register and output is 0, the FSM is in IDLE, cnt=0. mem_req=0 because M holds a bubble.
- Reset mid-access drops the request immediately, asynchronously.
- Zero-wait ack (ack in the request cycle): no stall. The load result appears in ReadDataW after the next edge.
- Ack N cycles after the request starts: stallM is high for N cycles. W sees N bubbles, then the instruction.
- Timeout: stallM is high for TIMEOUT-1 cycles. The abandon cycle has stallM=0.
- Back-to-back memory ops: the next request is asserted in the cycle after the previous one leaves M. No idle cycle is required.
- mem_ack while mem_req=0 is ignored.

## Test plan
- lw at 0x100, mem_rdata=0xDEADBEEF, zero-wait ack -> no stall; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1, ResultSrcW=01.
- lb at 0x103, rdata=0x80xxxxxx -> ReadDataW=0xFFFFFF80. lbu at the same address -> 0x00000080. lh at 0x102, rdata=0x8001xxxx -> 0xFFFF8001.
- sb at 0x101 with data 0x55 -> mem_be=0010, mem_wdata=0x55555555, mem_we=1, mem_addr=0x100. sh at 0x102 -> be=1100.
- lw, ack 3 cycles after request -> stallM=1 for exactly 3 cycles, EX/MEM holds, 3 bubbles (RegWriteW=0) then the load.
- lw with no ack, TIMEOUT=16 -> stallM=1 for 15 cycles, then bus_err=1 and RegWriteW=0 for that load; a subsequent add passes normally with bus_err still 1.
- lw at 0x102 -> mem_req stays 0, no stall, misalignW=1, RegWriteW=0. Assert reset during a WAIT -> all outputs 0, FSM in IDLE.
